// File: rtl/acc_skew_pkg.sv
// acc_skew_pkg: shared tag type, width helpers and
// result clamping for the skewed-column accumulator.
package acc_skew_pkg;

  localparam int MAXW = 64;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } skew_tag_t;

  function automatic int col_bits(input int a, input int g);
    return a + $clog2(g);
  endfunction

  function automatic int full_bits(
    input int a,
    input int g,
    input int n
  );
    return col_bits(a, g) + $clog2(n);
  endfunction

  // Returns {ovf, value}; value is sign-extended above zb bits.
  function automatic logic [MAXW:0] sat_or_wrap(
    input logic signed [MAXW-1:0] v,
    input int                     zb,
    input logic                   sat
  );
    logic signed [MAXW-1:0] hi, lo, wr, r;
    logic o;
    hi = (64'sd1 <<< (zb - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    wr = (v <<< (MAXW - zb)) >>> (MAXW - zb);
    o  = (v > hi) || (v < lo);
    r  = (o && sat) ? (v[MAXW-1] ? lo : hi) : wr;
    return {o, r};
  endfunction

endpackage

// File: rtl/acc_skew_multi_lane.sv
// acc_chan_lane: one channel's column accumulators,
// skewed reduction and sat/wrap of the group total.
module acc_chan_lane
  import acc_skew_pkg::*;
#(
  parameter int arraySize = 4,
  parameter int aBits     = 20,
  parameter int zBits     = 28,
  parameter int maxGroup  = 4,
  parameter int satMode   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  skew_tag_t [arraySize-1:0]    i_tap,
  input  logic [arraySize*aBits-1:0]   i_data,
  output logic [zBits-1:0]             o_res,
  output logic                         o_ovf
);

  localparam int CB = col_bits(aBits, maxGroup);
  localparam int FB = full_bits(aBits, maxGroup, arraySize);

  logic [MAXW:0] w_sow;

  // Partial sums ride the same skew as the last tag, so a
  // back-to-back group can reload column 0 before column N-1 ends.
  for (genvar j = 0; j < arraySize; j++) begin : g_col
    logic signed [CB-1:0] r_acc;
    logic signed [CB-1:0] w_d;
    logic signed [CB-1:0] w_next;
    logic signed [FB-1:0] r_psum;
    logic signed [FB-1:0] w_prev;

    assign w_d    = CB'($signed(i_data[j*aBits +: aBits]));
    assign w_next = i_tap[j].first ? w_d : r_acc + w_d;

    if (j == 0) begin : g_head
      assign w_prev = '0;
    end else begin : g_tail
      assign w_prev = g_col[j-1].r_psum;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc  <= '0;
        r_psum <= '0;
      end else begin
        if (i_tap[j].valid)
          r_acc <= w_next;
        if (i_tap[j].valid && i_tap[j].last)
          r_psum <= w_prev + FB'(w_next);
      end
    end
  end

  assign w_sow = sat_or_wrap(
    MAXW'(g_col[arraySize-1].r_psum), zBits, satMode != 0);
  assign o_res = w_sow[zBits-1:0];
  assign o_ovf = w_sow[MAXW];

endmodule

// File: rtl/acc_skew_multi.sv
// acc_skew_multi: multi-channel skewed-column group
// accumulator with output handshake and drop detection.
module acc_skew_multi
  import acc_skew_pkg::*;
#(
  parameter int arraySize   = 4,
  parameter int numChannels = 4,
  parameter int aBits       = 20,
  parameter int zBits       = 28,
  parameter int maxGroup    = 4,
  parameter int satMode     = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  interrupt,
  input  logic                                  valid,
  input  logic [$clog2(maxGroup+1)-1:0]         group_len,
  input  logic [numChannels*arraySize*aBits-1:0] data_in,
  input  logic                                  out_ready,
  input  logic                                  err_clr,
  output logic                                  out_valid,
  output logic [numChannels*zBits-1:0]          acc_out,
  output logic [numChannels-1:0]                ovf,
  output logic                                  drop_err
);

  localparam int cntBits = $clog2(maxGroup + 1);
  localparam int N       = arraySize;
  localparam int LW      = N * aBits;

  logic [cntBits-1:0] r_cnt, r_len, w_glen, w_len;
  logic w_beat, w_first, w_last, w_done;
  skew_tag_t w_tag0;
  skew_tag_t [N:1] r_tag;
  skew_tag_t [N-1:0] w_tap;
  logic [numChannels-1:0][zBits-1:0] w_res, r_res;
  logic [numChannels-1:0] w_ovf, r_ovf;
  logic r_ov, r_drop;

  always_comb begin
    w_glen = group_len;
    if (group_len == '0)
      w_glen = cntBits'(1);
    else if (group_len > cntBits'(maxGroup))
      w_glen = cntBits'(maxGroup);
  end

  assign w_first = (r_cnt == '0);
  assign w_len   = w_first ? w_glen : r_len;
  assign w_last  = (r_cnt == w_len - cntBits'(1));
  assign w_beat  = valid && !interrupt;
  assign w_tag0  = {w_beat, w_beat & w_first, w_beat & w_last};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_len <= '0;
    end else if (interrupt) begin
      r_cnt <= '0;
    end else if (valid) begin
      if (w_first)
        r_len <= w_glen;
      r_cnt <= w_last ? '0 : r_cnt + cntBits'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag <= '0;
    end else begin
      r_tag[1] <= w_tag0;
      for (int k = 2; k <= N; k++)
        r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_tap[0] = w_tag0;
  for (genvar j = 1; j < N; j++) begin : g_tap
    assign w_tap[j] = r_tag[j];
  end

  // Last has cleared column N-1: every lane's total is final.
  assign w_done = r_tag[N].valid && r_tag[N].last;

  for (genvar c = 0; c < numChannels; c++) begin : g_lane
    acc_chan_lane #(
      .arraySize (arraySize),
      .aBits     (aBits),
      .zBits     (zBits),
      .maxGroup  (maxGroup),
      .satMode   (satMode)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_tap  (w_tap),
      .i_data (data_in[c*LW +: LW]),
      .o_res  (w_res[c]),
      .o_ovf  (w_ovf[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ov   <= 1'b0;
      r_res  <= '0;
      r_ovf  <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_done && (!r_ov || out_ready)) begin
        r_ov  <= 1'b1;
        r_res <= w_res;
        r_ovf <= w_ovf;
      end else if (out_ready) begin
        r_ov <= 1'b0;
      end
      if (w_done && r_ov && !out_ready)
        r_drop <= 1'b1;
      else if (err_clr)
        r_drop <= 1'b0;
    end
  end

  assign out_valid = r_ov;
  assign acc_out   = r_res;
  assign ovf       = r_ovf;
  assign drop_err  = r_drop;

endmodule
